// File: rtl/load_writeback_unit.sv
// load_writeback_unit
// Multi-cycle RV32I load unit: checks the load in IDLE, issues a word-aligned
// request/acknowledge read, aligns and extends the returned word, and writes
// it to the register file in one cycle. Misaligned loads, illegal encodings
// and memory timeouts produce a one-cycle error pulse instead.

module load_writeback_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ld_valid,
   input  logic [31:0] i_ld_addr,
   input  logic [2:0]  i_ld_funct3,
   input  logic [4:0]  i_ld_rd,
   output logic        o_stall,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd_data,
   output logic        o_rd_wren,
   output logic        o_ld_err
);

   // Counter is wide enough to hold TIMEOUT itself, even though it only
   // ever reaches TIMEOUT-1 before the unit gives up.
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WB   = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [31:0]     cap_addr;
   logic [2:0]      cap_funct3;
   logic [4:0]      cap_rd;
   logic [CW-1:0]   count;
   logic [31:0]     wb_data;
   logic [4:0]      wb_addr;
   logic            check_err;
   logic            accept;

   // Encodings outside the five RV32I load forms are rejected outright.
   function automatic logic funct3_legal(input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Halves must be 2-byte aligned and words 4-byte aligned; bytes never fault.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      bad = 1'b0;
      if ((f3 == F3_LH || f3 == F3_LHU) && off[0])
         bad = 1'b1;
      if (f3 == F3_LW && off != 2'b00)
         bad = 1'b1;
      return bad;
   endfunction

   // Selects the addressed byte/half out of the memory word and extends it.
   function automatic logic [31:0] align(input logic [31:0] word,
                                         input logic [1:0]  off,
                                         input logic [2:0]  f3);
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      logic [31:0] res;
      case (off)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_LB:   res = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  res = {24'd0, byte_sel};
         F3_LH:   res = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  res = {16'd0, half_sel};
         default: res = word;
      endcase
      return res;
   endfunction

   // Front-end check of the incoming load, only meaningful while IDLE.
   always_comb begin
      check_err = 1'b0;
      accept    = 1'b0;
      if (state == IDLE && i_ld_valid) begin
         check_err = !funct3_legal(i_ld_funct3) || misaligned(i_ld_funct3, i_ld_addr[1:0]);
         accept    = !check_err;
      end
   end

   // Next-state logic; an ack on the final allowed cycle beats the timeout.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept)
               next_state = REQ;
         end
         REQ: begin
            if (i_mem_ack)
               next_state = WB;
            else if (count == LAST)
               next_state = ERR;
         end
         WB:      next_state = IDLE;
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register plus captured load fields, wait counter and write-back data.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         cap_addr   <= '0;
         cap_funct3 <= '0;
         cap_rd     <= '0;
         count      <= '0;
         wb_data    <= '0;
         wb_addr    <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            cap_addr   <= i_ld_addr;
            cap_funct3 <= i_ld_funct3;
            cap_rd     <= i_ld_rd;
            count      <= '0;
         end
         if (state == REQ) begin
            if (i_mem_ack) begin
               wb_data <= align(i_mem_rdata, cap_addr[1:0], cap_funct3);
               wb_addr <= cap_rd;
            end else if (count != LAST) begin
               count <= count + 1'b1;
            end
         end
      end
   end

   // Output decode; reset forces every control output low immediately.
   always_comb begin
      o_stall    = 1'b0;
      o_mem_req  = 1'b0;
      o_mem_addr = '0;
      o_rd_wren  = 1'b0;
      o_ld_err   = 1'b0;
      o_rd_addr  = wb_addr;
      o_rd_data  = wb_data;
      if (!i_reset) begin
         case (state)
            IDLE: begin
               o_stall  = accept;
               o_ld_err = check_err;
            end
            REQ: begin
               o_stall    = 1'b1;
               o_mem_req  = 1'b1;
               o_mem_addr = {cap_addr[31:2], 2'b00};
            end
            WB: begin
               o_rd_wren = (cap_rd != 5'd0);
            end
            ERR: begin
               o_ld_err = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed testbench for load_writeback_unit (built with TIMEOUT=4).

module tb_load_writeback_unit;

   logic        clk;
   logic        reset;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [2:0]  ld_funct3;
   logic [4:0]  ld_rd;
   logic        stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_wren;
   logic        ld_err;

   int checks = 0;
   int errors = 0;

   load_writeback_unit #(.TIMEOUT(4)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_ld_valid  (ld_valid),
      .i_ld_addr   (ld_addr),
      .i_ld_funct3 (ld_funct3),
      .i_ld_rd     (ld_rd),
      .o_stall     (stall),
      .o_mem_req   (mem_req),
      .o_mem_addr  (mem_addr),
      .i_mem_ack   (mem_ack),
      .i_mem_rdata (mem_rdata),
      .o_rd_addr   (rd_addr),
      .o_rd_data   (rd_data),
      .o_rd_wren   (rd_wren),
      .o_ld_err    (ld_err)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one load with ack on the first REQ cycle and records what was seen.
   // Called at posedge+1; returns at posedge+1 of the cycle after WB.
   task automatic run_load(input  logic [31:0] a, input logic [2:0] f3,
                           input  logic [4:0]  rd, input logic [31:0] rdata,
                           output logic [31:0] data, output logic [4:0] wa,
                           output logic wren, output logic [31:0] maddr,
                           output logic stall0, output logic stall_wb,
                           output logic errs, output logic req1);
      ld_valid = 1'b1; ld_addr = a; ld_funct3 = f3; ld_rd = rd;
      @(negedge clk);
      stall0 = stall;
      errs   = ld_err;
      @(posedge clk); #1;
      ld_valid = 1'b0; ld_addr = 32'hFFFF_FFFF; ld_funct3 = 3'b111; ld_rd = 5'd31;
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      req1  = mem_req;
      maddr = mem_addr;
      errs  = errs | ld_err;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      @(negedge clk);
      data     = rd_data;
      wa       = rd_addr;
      wren     = rd_wren;
      stall_wb = stall;
      errs     = errs | ld_err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; ld_valid = 1'b1; ld_addr = 32'h100; ld_funct3 = 3'b010; ld_rd = 5'd3;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      #22;
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || rd_wren !== 1'b0 || ld_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: stall=%b req=%b wren=%b err=%b, required all 0", stall, mem_req, rd_wren, ld_err);
      end
      checks++;
      if (rd_data !== 32'h0 || rd_addr !== 5'd0 || mem_addr !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: rd_data=%h rd_addr=%0d mem_addr=%h, required 0", rd_data, rd_addr, mem_addr);
      end
      ld_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || ld_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_idle: stall=%b req=%b err=%b, required 0", stall, mem_req, ld_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_lw();
      logic [31:0] d, ma; logic [4:0] wa; logic w, s0, swb, e, r1;
      run_load(32'h0000_1008, 3'b010, 5'd5, 32'hDEAD_BEEF, d, wa, w, ma, s0, swb, e, r1);
      checks++;
      if (ma !== 32'h0000_1008 || r1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lw_req: req=%b addr=%h, required 1 / 00001008", r1, ma);
      end
      checks++;
      if (w !== 1'b1 || wa !== 5'd5 || d !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL lw_wb: wren=%b rd=%0d data=%h, required 1 / 5 / deadbeef", w, wa, d);
      end
      checks++;
      if (s0 !== 1'b1 || swb !== 1'b0 || e !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lw_stall: stall0=%b stall_wb=%b err=%b, required 1/0/0", s0, swb, e);
      end
      @(negedge clk);
      checks++;
      if (rd_wren !== 1'b0 || rd_data !== 32'hDEAD_BEEF || rd_addr !== 5'd5) begin
         errors++;
         $display("[TB] FAIL lw_hold: wren=%b rd=%0d data=%h, required 0 / 5 / deadbeef", rd_wren, rd_addr, rd_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_extension();
      logic [31:0] addrs [5] = '{32'h2003, 32'h2003, 32'h2002, 32'h2000, 32'h2001};
      logic [2:0]  f3s   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
      logic [31:0] exps  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_007F};
      logic [31:0] d, ma; logic [4:0] wa; logic w, s0, swb, e, r1;
      for (int i = 0; i < 5; i++) begin
         run_load(addrs[i], f3s[i], 5'(i + 10), 32'h80FF_7F01, d, wa, w, ma, s0, swb, e, r1);
         checks++;
         if (d !== exps[i] || w !== 1'b1 || wa !== 5'(i + 10) || ma !== 32'h2000) begin
            errors++;
            $display("[TB] FAIL ext_%0d: data=%h wren=%b rd=%0d maddr=%h, required %h / 1 / %0d / 00002000",
                     i, d, w, wa, ma, exps[i], i + 10);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [3] = '{32'h1002, 32'h1001, 32'h1000};
      logic [2:0]  f3s   [3] = '{3'b010, 3'b001, 3'b011};
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1; ld_addr = addrs[i]; ld_funct3 = f3s[i]; ld_rd = 5'd7;
         @(negedge clk);
         checks++;
         if (ld_err !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || rd_wren !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_%0d: err=%b stall=%b req=%b wren=%b, required 1/0/0/0", i, ld_err, stall, mem_req, rd_wren);
         end
         @(posedge clk); #1;
         ld_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (ld_err !== 1'b0 || mem_req !== 1'b0 || rd_wren !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_after_%0d: err=%b req=%b wren=%b, required 0", i, ld_err, mem_req, rd_wren);
         end
         @(posedge clk); #1;
      end
   endtask

   // ack_cycle = 0 means ack never arrives; otherwise ack on that REQ cycle.
   task automatic observe_wait(input int ack_cycle, output int req_n, output int err_n,
                               output int wren_n, output int err_at);
      req_n = 0; err_n = 0; wren_n = 0; err_at = -1;
      ld_valid = 1'b1; ld_addr = 32'h3000; ld_funct3 = 3'b010; ld_rd = 5'd9;
      @(posedge clk); #1;
      ld_valid = 1'b0;
      mem_rdata = 32'h1234_5678;
      for (int c = 1; c <= 8; c++) begin
         mem_ack = (c == ack_cycle);
         @(negedge clk);
         if (mem_req === 1'b1) req_n++;
         if (ld_err === 1'b1) begin err_n++; if (err_at < 0) err_at = c; end
         if (rd_wren === 1'b1) wren_n++;
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_timeout();
      int rq, er, wr, at;
      observe_wait(0, rq, er, wr, at);
      checks++;
      if (rq != 4 || er != 1 || wr != 0 || at != 5) begin
         errors++;
         $display("[TB] FAIL timeout: req_cycles=%0d err_cycles=%0d wren=%0d err_at=%0d, required 4/1/0/5", rq, er, wr, at);
      end
   endtask

   task automatic test_ack_last();
      int rq, er, wr, at;
      observe_wait(4, rq, er, wr, at);
      checks++;
      if (rq != 4 || er != 0 || wr != 1) begin
         errors++;
         $display("[TB] FAIL ack_last: req_cycles=%0d err_cycles=%0d wren=%0d, required 4/0/1", rq, er, wr);
      end
      checks++;
      if (rd_data !== 32'h1234_5678 || rd_addr !== 5'd9) begin
         errors++;
         $display("[TB] FAIL ack_last_data: data=%h rd=%0d, required 12345678 / 9", rd_data, rd_addr);
      end
   endtask

   task automatic test_rd_zero();
      logic [31:0] d, ma; logic [4:0] wa; logic w, s0, swb, e, r1;
      run_load(32'h0000_4000, 3'b010, 5'd0, 32'hCAFE_F00D, d, wa, w, ma, s0, swb, e, r1);
      checks++;
      if (r1 !== 1'b1 || ma !== 32'h4000 || w !== 1'b0 || swb !== 1'b0 || s0 !== 1'b1 || e !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_zero: req=%b maddr=%h wren=%b stall0=%b stall_wb=%b err=%b, required 1/00004000/0/1/0/0",
                  r1, ma, w, s0, swb, e);
      end
   endtask

   task automatic test_reset_mid_req();
      int bad_w = 0, bad_e = 0;
      logic [31:0] d, ma; logic [4:0] wa; logic w, s0, swb, e, r1;
      ld_valid = 1'b1; ld_addr = 32'h5004; ld_funct3 = 3'b010; ld_rd = 5'd12;
      @(posedge clk); #1;
      ld_valid = 1'b0; mem_ack = 1'b0;
      @(posedge clk); #1;
      #2;
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_req_pre: req=%b, required 1", mem_req);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_req_reset: req=%b stall=%b, required 0/0", mem_req, stall);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rd_wren === 1'b1) bad_w++;
         if (ld_err === 1'b1 || mem_req === 1'b1) bad_e++;
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      checks++;
      if (bad_w != 0 || bad_e != 0) begin
         errors++;
         $display("[TB] FAIL mid_req_after: wren_cycles=%0d err_or_req_cycles=%0d, required 0/0", bad_w, bad_e);
      end
      run_load(32'h0000_6000, 3'b010, 5'd14, 32'h0BAD_CAFE, d, wa, w, ma, s0, swb, e, r1);
      checks++;
      if (w !== 1'b1 || wa !== 5'd14 || d !== 32'h0BAD_CAFE || e !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_req_next: wren=%b rd=%0d data=%h err=%b, required 1/14/0badcafe/0", w, wa, d, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d, ma; logic [4:0] wa; logic w, s0, swb, e, r1;
      run_load(32'h0000_7001, 3'b100, 5'd20, 32'h0000_A500, d, wa, w, ma, s0, swb, e, r1);
      checks++;
      if (d !== 32'h0000_00A5 || w !== 1'b1 || wa !== 5'd20) begin
         errors++;
         $display("[TB] FAIL b2b_first: data=%h wren=%b rd=%0d, required 000000a5/1/20", d, w, wa);
      end
      run_load(32'h0000_7002, 3'b001, 5'd21, 32'h8001_0000, d, wa, w, ma, s0, swb, e, r1);
      checks++;
      if (s0 !== 1'b1 || d !== 32'hFFFF_8001 || w !== 1'b1 || wa !== 5'd21 || ma !== 32'h7000) begin
         errors++;
         $display("[TB] FAIL b2b_second: stall0=%b data=%h wren=%b rd=%0d maddr=%h, required 1/ffff8001/1/21/00007000",
                  s0, d, w, wa, ma);
      end
   endtask

   // Runs every scenario in order, then prints the summary.
   initial begin
      test_reset();
      test_lw();
      test_extension();
      test_errors();
      test_timeout();
      test_ack_last();
      test_rd_zero();
      test_reset_mid_req();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_writeback_unit.md
# load_writeback_unit

- Multi-cycle load unit that produces the register-file write port (`rd` address, data, write-enable) for RV32I loads.
- Accepts a load from execute and stalls the core.
- Issues a word-aligned request/acknowledge read to data memory, then aligns and sign- or zero-extends the returned word.
- Writes the result back to the register file in a single cycle, or signals a load error.

## Interface
Parameters:
- TIMEOUT, 16, maximum number of REQ cycles waiting for `i_mem_ack` before aborting (must be ≥1).

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_ld_valid  in  1  load present from execute; held high by the core while `o_stall`=1.
- i_ld_addr  in  32  byte address.
- i_ld_funct3  in  3  load type:
  - LB=000, LH=001, LW=010 (signed forms).
  - LBU=100, LHU=101 (unsigned forms).
  - Any other encoding is illegal.
- i_ld_rd  in  5  destination register.
- o_stall  out  1  core must hold its current instruction.
- o_mem_req  out  1  memory read request.
- o_mem_addr  out  32  word-aligned request address `{addr[31:2],2'b00}`.
- i_mem_ack  in  1  memory returns data this cycle.
- i_mem_rdata  in  32  memory read word; valid only when `i_mem_ack`=1.
- o_rd_addr  out  5  register-file write address.
- o_rd_data  out  32  register-file write data.
- o_rd_wren  out  1  register-file write enable.
- o_ld_err  out  1  one-cycle load error pulse (misaligned, illegal funct3, or timeout).

## Operation
- States: IDLE, REQ, WB, ERR.
- Captured registers: addr, funct3, rd, data (32 b); timeout counter of width clog2(TIMEOUT+1).

IDLE:
- Condition for a check error: `i_ld_valid`=1 and any of:
  - funct3 is illegal;
  - LH/LHU with addr[0]=1;
  - LW with addr[1:0]≠00.
- On a check error (combinational): `o_ld_err`=1, `o_stall`=0, no memory access, stay in IDLE.
- On a legal `i_ld_valid`: `o_stall`=1; capture addr, funct3 and rd; clear the counter; go to REQ.

REQ:
- `o_mem_req`=1, `o_mem_addr`=captured word address, `o_stall`=1.
- If `i_mem_ack`=1: capture `i_mem_rdata`, go to WB.
- Else if counter = TIMEOUT-1: go to ERR.
- Else: counter += 1.
- An ack arriving on the last allowed cycle wins over the timeout.

WB:
- `o_rd_wren`=1 when captured rd≠0; forced to 0 for rd=0 (x0 is never written).
- `o_rd_addr`=rd, `o_rd_data`=aligned result, `o_stall`=0.
- Always return to IDLE.

ERR:
- `o_ld_err`=1, `o_stall`=0, no write; return to IDLE.

Alignment (off = addr[1:0]):
- LB/LBU: byte = data[8·off+7 : 8·off]; sign-extend for LB, zero-extend for LBU.
- LH/LHU: half = data[31:16] if off[1]=1, else data[15:0]; sign-extend for LH, zero-extend for LHU.
- LW: data unchanged.

Output rules:
- Outputs not named for a state are 0.
- `o_rd_addr` and `o_rd_data` hold their last values outside WB.

## Timing
- Reset (asynchronous, any state): state←IDLE; counter, captured registers and all outputs ←0, including `o_stall` and `o_mem_req`.
  - Reset during REQ drops `o_mem_req` immediately.
  - A reset-aborted load never writes the register file and never flags an error.
- Minimum latency, with ack on the first REQ cycle:
  - cycle 0: IDLE accepts the load;
  - cycle 1: REQ;
  - cycle 2: WB.
  - The core stalls for 2 cycles and advances at the end of the WB cycle.
- Each additional REQ cycle without ack adds one cycle of latency and one stall cycle.
- Timeout: REQ lasts exactly TIMEOUT cycles without ack, then ERR follows for 1 cycle.
- `o_mem_req` is level-held from REQ entry until the ack cycle inclusive.
  - `o_mem_addr` is stable throughout.
  - `i_mem_ack` outside REQ is ignored.
- `i_ld_*` inputs are sampled only in IDLE.
  - Changes while in REQ, WB or ERR have no effect.
  - A new load is accepted no earlier than the cycle after WB or ERR.
- Back-to-back loads: a load presented in the cycle after WB is accepted normally; there is no dead cycle beyond the IDLE acceptance cycle.

## Test plan
- LW, addr 0x0000_1008, rd=5, ack on first REQ cycle with rdata 0xDEADBEEF:
  - `o_mem_addr`=0x1008;
  - cycle 2: `o_rd_wren`=1, rd 5, data 0xDEADBEEF;
  - `o_stall` high for cycles 0–1.
- Byte/half extension, rdata 0x80FF7F01:
  - LB @+3 → 0xFFFFFF80.
  - LBU @+3 → 0x00000080.
  - LH @+2 → 0xFFFF80FF.
  - LHU @+0 → 0x00007F01.
  - LB @+1 → 0x0000007F.
- Misaligned/illegal, each with no `o_mem_req` and no write:
  - LW @0x1002 → `o_ld_err` pulse in the same cycle, `o_stall`=0.
  - LH @0x1001 → same.
  - funct3=011 → same.
- Timeout, TIMEOUT=4, ack never asserted:
  - `o_mem_req` high exactly 4 cycles;
  - then 1 cycle of `o_ld_err`;
  - no `o_rd_wren`.
- Same setup, ack on the 4th REQ cycle: WB occurs with no error.
- rd=0 LW with ack: memory is accessed, `o_rd_wren` stays 0 in WB, `o_stall` releases normally.
- Assert `i_reset` mid-REQ, during the 2nd wait cycle:
  - `o_mem_req` falls immediately;
  - after reset release, no write and no error;
  - the next LW completes normally.
